// File: rtl/sync_pulse_pkg.sv
// Timing constants and helpers shared by the VGA sync generator.
// Default timing is 640x480 @ 60 Hz with a 25 MHz pixel clock.
package sync_pulse_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_CNT_W     = 10;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // First count of the sync window (sync starts right after the front porch).
  function automatic int sync_lo_start(input int visible, input int front);
    return visible + front;
  endfunction

  // Last count of the sync window (inclusive).
  function automatic int sync_lo_end(input int visible, input int front, input int sync);
    return visible + front + sync - 1;
  endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// One timing axis: a wrap counter advancing on i_inc, plus a registered
// active-low pulse that is low while the count lies in [LOW_START, LOW_END].
// The pulse is decoded from the next count so it lines up with o_cnt.
module sync_axis_counter
  import sync_pulse_pkg::*;
#(
  parameter int CNT_W     = VGA_CNT_W,
  parameter int TOTAL     = VGA_H_TOTAL,
  parameter int LOW_START = 656,
  parameter int LOW_END   = 751
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_wrap,
  output logic             o_pulse_n
);

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LO_S  = CNT_W'(LOW_START);
  localparam logic [CNT_W-1:0] LO_E  = CNT_W'(LOW_END);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pulse_n;
  logic             w_wrap;

  // Next count: hold unless incremented, wrap to zero after the last count.
  always_comb begin
    w_wrap    = i_inc && (r_cnt == LAST);
    w_cnt_nxt = r_cnt;
    if (i_inc) begin
      w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  // Count register and pulse decoded from the count it is about to hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_pulse_n <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_pulse_n <= !((w_cnt_nxt >= LO_S) && (w_cnt_nxt <= LO_E));
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_wrap    = w_wrap;
  assign o_pulse_n = r_pulse_n;

endmodule

// File: rtl/sync_pulse_gen.sv
// VGA timing generator: free-running horizontal/vertical counters driving
// active-low H/V sync pulses. The vertical axis advances once per line.
// Optional macro SYNC_PULSE_DE_EN adds o_col/o_row/o_active outputs that are
// registered and aligned with H_pulse/V_pulse.
module sync_pulse_gen
  import sync_pulse_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int CNT_W     = VGA_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  output logic             H_pulse,
  output logic             V_pulse
`ifdef SYNC_PULSE_DE_EN
  ,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_active
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_cnt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_unused;

  sync_axis_counter #(
    .CNT_W     (CNT_W),
    .TOTAL     (H_TOTAL),
    .LOW_START (sync_lo_start(H_VISIBLE, H_FRONT)),
    .LOW_END   (sync_lo_end(H_VISIBLE, H_FRONT, H_SYNC))
  ) u_h_axis (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_inc     (1'b1),
    .o_cnt     (w_h_cnt),
    .o_cnt_nxt (w_h_nxt),
    .o_wrap    (w_h_wrap),
    .o_pulse_n (H_pulse)
  );

  sync_axis_counter #(
    .CNT_W     (CNT_W),
    .TOTAL     (V_TOTAL),
    .LOW_START (sync_lo_start(V_VISIBLE, V_FRONT)),
    .LOW_END   (sync_lo_end(V_VISIBLE, V_FRONT, V_SYNC))
  ) u_v_axis (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_inc     (w_h_wrap),
    .o_cnt     (w_v_cnt),
    .o_cnt_nxt (w_v_nxt),
    .o_wrap    (w_v_wrap),
    .o_pulse_n (V_pulse)
  );

`ifdef SYNC_PULSE_DE_EN
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VISIBLE);

  logic r_active;

  // Display-enable decoded from the next counts so it aligns with o_col/o_row.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_active <= 1'b0;
    end else begin
      r_active <= (w_h_nxt < H_VIS_C) && (w_v_nxt < V_VIS_C);
    end
  end

  assign o_col    = w_h_cnt;
  assign o_row    = w_v_cnt;
  assign o_active = r_active;
  assign w_unused = &{1'b0, w_v_wrap};
`else
  assign w_unused = &{1'b0, w_v_wrap, w_h_cnt, w_v_cnt, w_h_nxt, w_v_nxt};
`endif

endmodule

// File: tb/tb_sync_pulse_gen.sv
// Bench for sync_pulse_gen: a full-size 640x480 instance for horizontal timing
// and asynchronous reset, and a shrunken-timing instance for whole-frame checks.
module tb_sync_pulse_gen;

  localparam int CW = 10;

  // Shrunken timing for instance B: H 8+2+3+2=15, V 6+2+2+3=13.
  localparam int BH_TOT = 15;
  localparam int BV_TOT = 13;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  logic ha, va, hb, vb;
`ifdef SYNC_PULSE_DE_EN
  logic [CW-1:0] col_a, row_a, col_b, row_b;
  logic          act_a, act_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int edges_a = 0;

  always #20 clk = ~clk;

  sync_pulse_gen u_a (
    .CLK     (clk),
    .RST_N   (rst_a_n),
    .H_pulse (ha),
    .V_pulse (va)
`ifdef SYNC_PULSE_DE_EN
    ,
    .o_col   (col_a),
    .o_row   (row_a),
    .o_active(act_a)
`endif
  );

  sync_pulse_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CNT_W(CW)
  ) u_b (
    .CLK     (clk),
    .RST_N   (rst_b_n),
    .H_pulse (hb),
    .V_pulse (vb)
`ifdef SYNC_PULSE_DE_EN
    ,
    .o_col   (col_b),
    .o_row   (row_b),
    .o_active(act_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_a_to(input int n);
    while (edges_a < n) begin
      @(posedge clk);
      edges_a++;
    end
    #1;
  endtask

  typedef struct {
    int   e;
    logic h;
    logic v;
  } vec_t;

  vec_t tab[14];

  initial begin
    int   vlow_cnt;
    int   act_cnt;
    int   fall1;
    int   fall2;
    logic prev_v;
    int   hm;
    int   vm;

    tab = '{
      '{0,    1'b1, 1'b1},
      '{1,    1'b1, 1'b1},
      '{2,    1'b1, 1'b1},
      '{655,  1'b1, 1'b1},
      '{656,  1'b0, 1'b1},
      '{700,  1'b0, 1'b1},
      '{751,  1'b0, 1'b1},
      '{752,  1'b1, 1'b1},
      '{799,  1'b1, 1'b1},
      '{800,  1'b1, 1'b1},
      '{1455, 1'b1, 1'b1},
      '{1456, 1'b0, 1'b1},
      '{1551, 1'b0, 1'b1},
      '{1552, 1'b1, 1'b1}
    };

    // Reset held for 5 clocks on both instances.
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_a_H", 32'(ha), 32'd1);
    chk("rst_a_V", 32'(va), 32'd1);
    chk("rst_b_H", 32'(hb), 32'd1);
    chk("rst_b_V", 32'(vb), 32'd1);
`ifdef SYNC_PULSE_DE_EN
    chk("rst_a_col", 32'(col_a), 32'd0);
    chk("rst_a_row", 32'(row_a), 32'd0);
    chk("rst_a_act", 32'(act_a), 32'd0);
`endif

    // Release A away from the clock edge; edge numbers count from here.
    rst_a_n = 1'b1;
    edges_a = 0;
    foreach (tab[i]) begin
      step_a_to(tab[i].e);
      chk($sformatf("A_H_e%0d", tab[i].e), 32'(ha), 32'(tab[i].h));
      chk($sformatf("A_V_e%0d", tab[i].e), 32'(va), 32'(tab[i].v));
`ifdef SYNC_PULSE_DE_EN
      chk($sformatf("A_col_e%0d", tab[i].e), 32'(col_a), 32'(tab[i].e % 800));
      chk($sformatf("A_row_e%0d", tab[i].e), 32'(row_a), 32'(tab[i].e / 800));
      chk($sformatf("A_act_e%0d", tab[i].e), 32'(act_a),
          (tab[i].e == 0) ? 32'd0 : 32'((tab[i].e % 800) < 640));
`endif
    end

    // Asynchronous reset in the middle of a fresh line's sync pulse (h=700).
    @(negedge clk);
    rst_a_n = 1'b0;
    edges_a = 0;
    #1;
    rst_a_n = 1'b1;
    step_a_to(700);
    chk("A_pre_async_H", 32'(ha), 32'd0);
    @(negedge clk);
    #5;
    rst_a_n = 1'b0;
    #1;
    chk("A_async_H", 32'(ha), 32'd1);
    chk("A_async_V", 32'(va), 32'd1);
`ifdef SYNC_PULSE_DE_EN
    chk("A_async_col", 32'(col_a), 32'd0);
    chk("A_async_act", 32'(act_a), 32'd0);
`endif
    repeat (3) @(negedge clk);
    chk("A_held_H", 32'(ha), 32'd1);
    rst_a_n = 1'b1;
    edges_a = 0;
    step_a_to(1);
    chk("A_restart_H_e1", 32'(ha), 32'd1);
`ifdef SYNC_PULSE_DE_EN
    chk("A_restart_col_e1", 32'(col_a), 32'd1);
`endif
    step_a_to(655);
    chk("A_restart_H_e655", 32'(ha), 32'd1);
    step_a_to(656);
    chk("A_restart_H_e656", 32'(ha), 32'd0);

    // Two full frames on the shrunken instance, checked every edge.
    @(negedge clk);
    rst_b_n  = 1'b1;
    vlow_cnt = 0;
    act_cnt  = 0;
    fall1    = -1;
    fall2    = -1;
    prev_v   = vb;
    for (int n = 1; n <= 2 * BH_TOT * BV_TOT; n++) begin
      @(posedge clk);
      #1;
      hm = n % BH_TOT;
      vm = (n / BH_TOT) % BV_TOT;
      chk($sformatf("B_H_n%0d", n), 32'(hb), 32'(!(hm >= 10 && hm <= 12)));
      chk($sformatf("B_V_n%0d", n), 32'(vb), 32'(!(vm >= 8 && vm <= 9)));
`ifdef SYNC_PULSE_DE_EN
      chk($sformatf("B_col_n%0d", n), 32'(col_b), 32'(hm));
      chk($sformatf("B_row_n%0d", n), 32'(row_b), 32'(vm));
      chk($sformatf("B_act_n%0d", n), 32'(act_b), 32'(hm < 8 && vm < 6));
      if (n <= BH_TOT * BV_TOT && act_b === 1'b1) act_cnt++;
`endif
      if (n <= BH_TOT * BV_TOT && vb === 1'b0) vlow_cnt++;
      if (prev_v === 1'b1 && vb === 1'b0) begin
        if (fall1 < 0) fall1 = n;
        else if (fall2 < 0) fall2 = n;
      end
      prev_v = vb;
    end
    chk("B_vlow_clocks", 32'(vlow_cnt), 32'd30);
    chk("B_vfall_first", 32'(fall1), 32'd120);
    chk("B_frame_period", 32'(fall2 - fall1), 32'(BH_TOT * BV_TOT));
`ifdef SYNC_PULSE_DE_EN
    chk("B_active_clocks", 32'(act_cnt), 32'd48);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
